// File: rtl/instr_fetch_seq.sv
// instr_fetch_seq: control end of the program-counter interface.
// Pulses the PC enable, reads the addressed instruction from a synchronous
// memory into an instruction register, hands it to the control unit over
// valid/ready, then steps or loads the PC (or freezes it on a halt opcode).
// Every output is driven straight from a flop.
//
// Optional build macro: IFETCH_COUNT_EN -- when defined, fetch_count is a
// saturating count of accepted instructions; otherwise it is tied to 0.
//
// Timing: the flop state names the phase whose outputs are on the pins this
// cycle. The memory read is launched on the same edge that the PC applies its
// update, so mem_addr is loaded with the address the PC is moving to
// (pc_addr + 1 or the jump target) rather than waiting a cycle for pc_addr.
module instr_fetch_seq #(
  parameter int          ADDR_W      = 9,
  parameter int          DATA_W      = 32,
  parameter logic [7:0]  HALT_OPCODE = 8'hFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] pc_addr,
  output logic              pc_en,
  output logic              pc_inc,
  output logic              pc_w_en,
  output logic [DATA_W-1:0] pc_data,
  output logic              pc_complete,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              jump_req,
  input  logic [ADDR_W-1:0] jump_target,
  output logic              done,
  output logic [15:0]       fetch_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_UPDATE,
    S_HALT
  } state_t;

  state_t              state_q, state_d;
  logic                pc_en_q, pc_en_d;
  logic                pc_inc_q, pc_inc_d;
  logic                pc_w_en_q, pc_w_en_d;
  logic [DATA_W-1:0]   pc_data_q, pc_data_d;
  logic                pc_complete_q, pc_complete_d;
  logic                mem_rd_en_q, mem_rd_en_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   instr_q, instr_d;
  logic                instr_valid_q, instr_valid_d;
  logic                done_q, done_d;

  logic handshake;
  logic is_halt;

  assign handshake = (state_q == S_HOLD) && instr_valid_q && instr_ready;
  assign is_halt   = (instr_q[DATA_W-1:DATA_W-8] == HALT_OPCODE);

  // Next-state and next-output logic for the fetch sequence.
  always_comb begin
    // NOTE: every _d gets a default before the case so no path leaves a
    // value unassigned (which would infer a latch). Strobes default low,
    // held registers default to their current value.
    state_d       = state_q;
    pc_en_d       = 1'b0;
    pc_inc_d      = 1'b0;
    pc_w_en_d     = 1'b0;
    mem_rd_en_d   = 1'b0;
    pc_data_d     = pc_data_q;
    pc_complete_d = pc_complete_q;
    mem_addr_d    = mem_addr_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    done_d        = done_q;

    unique case (state_q)
      S_IDLE: begin
        if (pc_en_q) begin
          // PC has been enabled; issue the first read at its current address.
          state_d     = S_REQ;
          mem_rd_en_d = 1'b1;
          mem_addr_d  = pc_addr;
        end else if (start) begin
          pc_en_d = 1'b1;
        end
      end

      S_REQ: begin
        state_d = S_WAIT;
      end

      S_WAIT: begin
        instr_d       = mem_rdata;
        instr_valid_d = 1'b1;
        state_d       = S_HOLD;
      end

      S_HOLD: begin
        if (handshake) begin
          instr_valid_d = 1'b0;
          if (is_halt) begin
            pc_complete_d = 1'b1;
            done_d        = 1'b1;
            state_d       = S_HALT;
          end else if (jump_req) begin
            pc_w_en_d = 1'b1;
            pc_data_d = DATA_W'(jump_target);
            state_d   = S_UPDATE;
          end else begin
            pc_inc_d = 1'b1;
            state_d  = S_UPDATE;
          end
        end
      end

      S_UPDATE: begin
        // PC applies its strobe on this edge; fetch from where it lands.
        state_d     = S_REQ;
        mem_rd_en_d = 1'b1;
        mem_addr_d  = pc_w_en_q ? pc_data_q[ADDR_W-1:0] : pc_addr + ADDR_W'(1);
      end

      S_HALT: begin
        state_d = S_HALT;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

`ifdef IFETCH_COUNT_EN
  logic [15:0] fetch_count_q, fetch_count_d;

  // Saturating count of accepted instructions, halt included.
  always_comb begin
    fetch_count_d = fetch_count_q;
    if (handshake && (fetch_count_q != 16'hFFFF)) begin
      fetch_count_d = fetch_count_q + 16'd1;
    end
  end

  assign fetch_count = fetch_count_q;
`else
  assign fetch_count = 16'd0;
`endif

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    if (rst) begin
      state_q       <= S_IDLE;
      pc_en_q       <= 1'b0;
      pc_inc_q      <= 1'b0;
      pc_w_en_q     <= 1'b0;
      pc_data_q     <= '0;
      pc_complete_q <= 1'b0;
      mem_rd_en_q   <= 1'b0;
      mem_addr_q    <= '0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      done_q        <= 1'b0;
`ifdef IFETCH_COUNT_EN
      fetch_count_q <= 16'd0;
`endif
    end else begin
      state_q       <= state_d;
      pc_en_q       <= pc_en_d;
      pc_inc_q      <= pc_inc_d;
      pc_w_en_q     <= pc_w_en_d;
      pc_data_q     <= pc_data_d;
      pc_complete_q <= pc_complete_d;
      mem_rd_en_q   <= mem_rd_en_d;
      mem_addr_q    <= mem_addr_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      done_q        <= done_d;
`ifdef IFETCH_COUNT_EN
      fetch_count_q <= fetch_count_d;
`endif
    end
  end

  assign pc_en       = pc_en_q;
  assign pc_inc      = pc_inc_q;
  assign pc_w_en     = pc_w_en_q;
  assign pc_data     = pc_data_q;
  assign pc_complete = pc_complete_q;
  assign mem_rd_en   = mem_rd_en_q;
  assign mem_addr    = mem_addr_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign done        = done_q;

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Self-checking bench for instr_fetch_seq: a behavioural PC and synchronous
// instruction memory close the loop; directed scenarios cover sequential
// fetch, backpressure, jump, address wrap, halt lock and mid-run reset.
module tb_instr_fetch_seq;

`ifdef IFETCH_COUNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [8:0]  pc_addr;
  logic        pc_en, pc_inc, pc_w_en, pc_complete;
  logic [31:0] pc_data;
  logic        mem_rd_en;
  logic [8:0]  mem_addr;
  logic [31:0] mem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        jump_req;
  logic [8:0]  jump_target = 9'd0;
  logic        done;
  logic [15:0] fetch_count;

  // Jump control: one-shot jump at jump_addr, or forced high.
  logic        jump_en = 1'b0;
  logic        jump_force = 1'b0;
  logic [8:0]  jump_addr = 9'd0;

  logic [31:0] mem [512];
  logic        pc_on;

  int n_checks = 0;
  int n_fail   = 0;

  // Monitor state, cleared by rst.
  logic [31:0] instr_q[$];
  logic [8:0]  addr_q[$];
  int          inc_cnt, w_en_cnt, pc_en_cnt, excl_err;
  logic [31:0] w_en_data;

  always #5 clk = ~clk;

  assign jump_req = jump_force |
                    (jump_en & (w_en_cnt == 0) & instr_valid & (pc_addr == jump_addr));

  instr_fetch_seq dut (
    .clk(clk), .rst(rst), .start(start), .pc_addr(pc_addr),
    .pc_en(pc_en), .pc_inc(pc_inc), .pc_w_en(pc_w_en), .pc_data(pc_data),
    .pc_complete(pc_complete), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .jump_req(jump_req), .jump_target(jump_target),
    .done(done), .fetch_count(fetch_count)
  );

  // Behavioural PC.
  always @(posedge clk) begin
    if (rst) begin
      pc_addr <= 9'd0;
      pc_on   <= 1'b0;
    end else begin
      if (pc_en) pc_on <= 1'b1;
      if (pc_on && !pc_complete) begin
        if (pc_w_en)     pc_addr <= pc_data[8:0];
        else if (pc_inc) pc_addr <= pc_addr + 9'd1;
      end
    end
  end

  // Synchronous instruction memory: data one cycle after the read strobe.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
  end

  // Transaction monitor sampling what the DUT sees at each edge.
  always @(posedge clk) begin
    if (rst) begin
      instr_q.delete();
      addr_q.delete();
      inc_cnt = 0; w_en_cnt = 0; pc_en_cnt = 0; excl_err = 0;
      w_en_data = 32'd0;
    end else begin
      if (instr_valid && instr_ready) instr_q.push_back(instr);
      if (mem_rd_en) addr_q.push_back(mem_addr);
      if (pc_inc) inc_cnt++;
      if (pc_w_en) begin w_en_cnt++; w_en_data = pc_data; end
      if (pc_en) pc_en_cnt++;
      if ((pc_inc && pc_w_en) || (pc_complete && (pc_inc || pc_w_en))) excl_err++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 512; i++) mem[i] = 32'h0000_0000;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    instr_ready = 1'b0;
    jump_en = 1'b0;
    jump_force = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("done_reached", 32'(done), 32'd1);
  endtask

  task automatic check_instrs(input string tag, input logic [31:0] exp[$]);
    check({tag, "_count"}, 32'(instr_q.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++)
      check($sformatf("%s[%0d]", tag, i),
            (i < instr_q.size()) ? instr_q[i] : 32'hDEAD_BEEF, exp[i]);
  endtask

  task automatic check_addrs(input string tag, input logic [8:0] exp[$]);
    check({tag, "_count"}, 32'(addr_q.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++)
      check($sformatf("%s[%0d]", tag, i),
            (i < addr_q.size()) ? 32'(addr_q[i]) : 32'hDEAD_BEEF, 32'(exp[i]));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_strobes"},
          32'({pc_en, pc_inc, pc_w_en, pc_complete, mem_rd_en, instr_valid, done}), 32'd0);
    check({tag, "_instr"}, instr, 32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_pc_data"}, pc_data, 32'd0);
    check({tag, "_fetch_count"}, 32'(fetch_count), 32'd0);
  endtask

  initial begin
    // ---------------- sequential fetch with backpressure ----------------
    clear_mem();
    mem[0] = 32'h1100_0000;
    mem[1] = 32'h2200_0000;
    mem[2] = 32'h3300_0000;
    mem[3] = 32'hFF00_0000;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("lat_pc_en", 32'({pc_en, mem_rd_en}), 32'b10);
    @(negedge clk);
    check("lat_rd_en", 32'({pc_en, mem_rd_en}), 32'b01);
    check("lat_mem_addr", 32'(mem_addr), 32'd0);
    @(negedge clk);
    check("lat_wait", 32'({mem_rd_en, instr_valid}), 32'b00);
    @(negedge clk);
    check("lat_valid", 32'(instr_valid), 32'd1);
    check("lat_instr", instr, 32'h1100_0000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("bp_instr_%0d", i), 32'({instr_valid, instr[31:24]}), 32'h111);
      check($sformatf("bp_strobes_%0d", i),
            32'({pc_en, pc_inc, pc_w_en, mem_rd_en}), 32'd0);
    end
    instr_ready = 1'b1;
    wait_done(200);
    check_instrs("seq_instr", '{32'h1100_0000, 32'h2200_0000, 32'h3300_0000, 32'hFF00_0000});
    check_addrs("seq_addr", '{9'd0, 9'd1, 9'd2, 9'd3});
    check("seq_inc_cnt", 32'(inc_cnt), 32'd3);
    check("seq_w_en_cnt", 32'(w_en_cnt), 32'd0);
    check("seq_pc_en_cnt", 32'(pc_en_cnt), 32'd1);
    check("seq_complete", 32'({pc_complete, done}), 32'b11);
    check("seq_fetch_count", 32'(fetch_count), CNT_ON ? 32'd4 : 32'd0);
    check("seq_excl", 32'(excl_err), 32'd0);

    // ---------------- jump, then halt lock ----------------
    do_reset();
    clear_mem();
    mem[0]   = 32'h0100_0000;
    mem[1]   = 32'h0200_0000;
    mem[2]   = 32'h0300_0000;
    mem[100] = 32'h6400_0000;
    mem[101] = 32'hFF00_0000;
    jump_addr   = 9'd2;
    jump_target = 9'd100;
    jump_en     = 1'b1;
    instr_ready = 1'b1;
    pulse_start();
    wait_done(200);
    check_instrs("jmp_instr",
                 '{32'h0100_0000, 32'h0200_0000, 32'h0300_0000, 32'h6400_0000, 32'hFF00_0000});
    check_addrs("jmp_addr", '{9'd0, 9'd1, 9'd2, 9'd100, 9'd101});
    check("jmp_w_en_cnt", 32'(w_en_cnt), 32'd1);
    check("jmp_pc_data", w_en_data, 32'd100);
    check("jmp_inc_cnt", 32'(inc_cnt), 32'd3);
    check("jmp_fetch_count", 32'(fetch_count), CNT_ON ? 32'd5 : 32'd0);
    check("jmp_excl", 32'(excl_err), 32'd0);

    start = 1'b1;
    jump_force = 1'b1;
    for (int i = 0; i < 4; i++) begin
      instr_ready = i[0];
      @(negedge clk);
      check($sformatf("halt_strobes_%0d", i),
            32'({pc_en, pc_inc, pc_w_en, mem_rd_en, instr_valid}), 32'd0);
      check($sformatf("halt_hold_%0d", i), 32'({pc_complete, done}), 32'b11);
    end
    start = 1'b0;
    jump_force = 1'b0;
    check("halt_instr", instr, 32'hFF00_0000);
    check("halt_pc_en_cnt", 32'(pc_en_cnt), 32'd1);

    // ---------------- address wrap ----------------
    do_reset();
    clear_mem();
    mem[0]   = 32'h0100_0000;
    mem[1]   = 32'hFF00_0000;
    mem[511] = 32'h5500_0000;
    jump_addr   = 9'd0;
    jump_target = 9'd511;
    jump_en     = 1'b1;
    instr_ready = 1'b1;
    pulse_start();
    wait_done(200);
    check_addrs("wrap_addr", '{9'd0, 9'd511, 9'd0, 9'd1});
    check_instrs("wrap_instr", '{32'h0100_0000, 32'h5500_0000, 32'h0100_0000, 32'hFF00_0000});
    check("wrap_inc_cnt", 32'(inc_cnt), 32'd2);
    check("wrap_excl", 32'(excl_err), 32'd0);

    // ---------------- reset during WAIT ----------------
    do_reset();
    jump_en = 1'b0;
    instr_ready = 1'b1;
    pulse_start();
    begin
      int n = 0;
      while (!(mem_rd_en && instr == 32'h0100_0000) && n < 100) begin
        @(negedge clk);
        n++;
      end
      check("mid_reached_req", 32'(mem_addr), 32'd1);
    end
    @(negedge clk);
    check("mid_in_wait", 32'({mem_rd_en, instr_valid}), 32'b00);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("mid_rst");
    rst = 1'b0;
    pulse_start();
    check("mid_restart_pc_en", 32'(pc_en), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
